// File: rtl/burst_fetch128.sv
`default_nettype none
// ============================================================================
// Module   : burst_fetch128
// Purpose  : Wishbone read initiator. Fetches one aligned line of BLEN
//            WID-bit beats with an incrementing burst, assembles the beats
//            into one line and signals it with a one-cycle valid pulse.
// Ports    : clk_i, rst_ni       - clock, asynchronous active-low reset
//            req_i, req_adr_i    - line request and any byte address in line
//            req_rdy_o           - idle, request is taken this cycle
//            line_o, line_vld_o  - assembled line (beat 0 in low bits), pulse
//            err_o               - abort pulse (watchdog builds only)
//            cyc_o, stb_o, we_o, cti_o, adr_o, ack_i, dat_i - Wishbone master
// Options  : BURST_FETCH_TIMEOUT_EN - adds an ack watchdog of TMO cycles and
//            the ERR state; otherwise a burst waits for acks indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module burst_fetch128 #(
    parameter int WID  = 128,
    parameter int BLEN = 4,
    parameter int AWID = 18,
    parameter int TMO  = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [AWID-1:0]     req_adr_i,
    output logic                req_rdy_o,
    output logic [BLEN*WID-1:0] line_o,
    output logic                line_vld_o,
    output logic                err_o,
    output logic                cyc_o,
    output logic                stb_o,
    output logic                we_o,
    output logic [2:0]          cti_o,
    output logic [AWID-1:0]     adr_o,
    input  logic                ack_i,
    input  logic [WID-1:0]      dat_i
);

    localparam int c_beat_w = $clog2(BLEN);
    localparam int c_byte_w = $clog2(WID / 8);
    localparam int c_off_w  = c_beat_w + c_byte_w;
    localparam logic [AWID-1:0]     c_line_mask = {{(AWID - c_off_w){1'b1}}, {c_off_w{1'b0}}};
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(BLEN - 1);

`ifdef BURST_FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [AWID-1:0]        r_base;
    logic [c_beat_w-1:0]    r_beat;
    logic [BLEN*WID-1:0]    r_line;
    logic                   w_last;
    logic                   w_tmo_hit;

    assign w_last = (r_beat == c_last_beat);

`ifdef BURST_FETCH_TIMEOUT_EN
    localparam int c_tmo_w = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TMO - 1);

    logic [c_tmo_w-1:0] r_tmo;

    // Idle cycles since burst entry or the most recent ack. Holding it at
    // zero outside BURST gives the clear-on-entry behaviour for free.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo <= '0;
        end else if (r_state != S_BURST || ack_i) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == S_BURST) && !ack_i && (r_tmo == c_tmo_last);
    assign err_o     = (r_state == S_ERR);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO > 0);
    assign w_tmo_hit    = 1'b0;
    assign err_o        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_i) w_state_nxt = S_BURST;
            S_BURST: begin
                if (ack_i && w_last) begin
                    w_state_nxt = S_DONE;
                end else if (w_tmo_hit) begin
`ifdef BURST_FETCH_TIMEOUT_EN
                    w_state_nxt = S_ERR;
`else
                    w_state_nxt = S_BURST;
`endif
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line base, beat counter and beat assembly. The beat counter is exactly
    // log2(BLEN) bits wide, so it wraps inside the line and the address can
    // never carry into the line-select bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base <= '0;
            r_beat <= '0;
            r_line <= '0;
        end else if (r_state == S_IDLE && req_i) begin
            r_base <= req_adr_i & c_line_mask;
            r_beat <= '0;
        end else if (r_state == S_BURST && ack_i) begin
            r_line[r_beat*WID +: WID] <= dat_i;
            r_beat                    <= r_beat + 1'b1;
        end
    end

    // Bus and client outputs decode only flops, never a combinational input.
    assign cyc_o      = (r_state == S_BURST);
    assign stb_o      = (r_state == S_BURST);
    assign we_o       = 1'b0;
    assign cti_o      = (r_state != S_BURST) ? 3'b000 :
                        (w_last ? 3'b111 : 3'b010);
    assign adr_o      = r_base | {{(AWID - c_off_w){1'b0}}, r_beat, {c_byte_w{1'b0}}};
    assign req_rdy_o  = (r_state == S_IDLE);
    assign line_vld_o = (r_state == S_DONE);
    assign line_o     = r_line;

endmodule
`default_nettype wire
